data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the MEM stage of the pipelined processor. It answers the stage's `datamem_en` / `rw` / `size` request with a byte-serial access to a 256-byte, big-endian, byte-wide storage array. The byte layout matches the instruction ROM. A word access takes four array cycles, a byte access takes one. `busy` stalls the pipeline and `done` marks completion.

## Interface
- `ADDR_W`, default 8: byte address width.
- `DEPTH`, default 256: number of bytes; must equal 2^`ADDR_W`.
- `clk` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `datamem_en` in 1: access request, sampled only in IDLE.
- `rw` in 1: 1 = read (load), 0 = write (store).
- `size` in 1: 1 = byte, 0 = word.
- `addr` in `ADDR_W`: byte address of the access; for words, the address of the MSB.
- `wdata` in 32: store data; byte stores use `wdata[7:0]`.
- `rdata` out 32: load result; byte loads are zero-extended.
- `busy` out 1: access in progress, state is XFER or DONE.
- `done` out 1: one-cycle completion pulse.

## Operation
- Storage is the byte array `Mem[0:DEPTH-1]`. It is not cleared by reset and can be preloaded hierarchically by the bench.
- Word image is {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}: big-endian, lowest address holds bits 31:24.
- FSM has three states: IDLE, XFER, DONE.
  - IDLE: if `datamem_en`=1, latch `addr`, `rw`, `size`, `wdata` into A, RW, SZ, WD, set k=0 and go to XFER. Otherwise stay.
  - XFER: perform one byte operation per cycle at address (A+k) mod DEPTH.
    - Word write: Mem[A+k] <= WD[31-8k -: 8].
    - Byte write: Mem[A] <= WD[7:0].
    - Word read: capture Mem[A+k] into byte lane 3-k of an assembly register.
    - Byte read: assembly register <= {24'b0, Mem[A]}.
    - Leave XFER after the last byte: k=3 for words, k=0 for bytes. Otherwise k <= k+1.
  - DONE: `done`=1. On reads, `rdata` <= assembly register at entry to DONE. Return to IDLE unconditionally.
- Requests are ignored outside IDLE. Input changes during XFER or DONE have no effect because the inputs were latched.
- A request present in the IDLE cycle following DONE is accepted. This gives back-to-back accesses with one IDLE gap.
- Address arithmetic is modulo DEPTH, so an unaligned word at 0xFE covers 0xFE, 0xFF, 0x00, 0x01. No alignment fault.
- `rdata` holds its value until the next read completes. Writes do not alter `rdata`.
- `datamem_en`=1 with `rw`=X is a requester error; behaviour is unspecified.

## Timing
- Reset values: state=IDLE, k=0, `busy`=0, `done`=0, `rdata`=32'h0.
- All outputs are registered or decoded from registered state. No combinational input-to-output path.
- Let cycle 0 be the IDLE cycle in which `datamem_en`=1 is sampled.
- Byte access: XFER in cycle 1, DONE in cycle 2. `done` is high in cycle 2 and `busy` is high in cycles 1–2.
- Word access: XFER in cycles 1–4, DONE in cycle 5. `done` is high in cycle 5 and `busy` is high in cycles 1–5.
- Write visibility: byte k of a store is in `Mem` from the edge ending XFER cycle k+1.
- Reset mid-access: the next edge forces IDLE with `busy`, `done` and `rdata` all 0.
  - Bytes already written remain in `Mem`, so a partial word is possible and is accepted.
  - No pending completion is reported.
- `reset` and `datamem_en` asserted in the same cycle: `reset` wins and the request is dropped.

## Structure
- A shared package holds:
  - state encodings ST_IDLE=2'b00, ST_XFER=2'b01, ST_DONE=2'b10;
  - SIZE_BYTE=1'b1, SIZE_WORD=1'b0;
  - RW_READ=1'b1, RW_WRITE=1'b0.
- One natural sub-module, `data_ram_byte`: a single-port byte-wide array with synchronous write and asynchronous read, 8-bit data and `ADDR_W` address.
  - It owns `Mem`; the bench preloads it as `<inst>.ram.Mem`.
  - The FSM, latches, counter and assembly register stay in `data_mem_responder`.

## Test plan
- After reset, preload Mem[0x10..0x13]=DE AD BE EF, then issue a word read at 0x10. Required: `busy` high in cycles 1–5, `done` only in cycle 5, `rdata`=32'hDEADBEEF in cycle 5 and held afterwards.
- Word write 32'h11223344 at 0x20, then byte read at 0x22. Required: Mem[0x20..0x23]=11 22 33 44 and `rdata`=32'h00000033, with `done` 2 cycles after the byte request.
- Byte write `wdata`=32'hFFFFFFA5 at 0x05. Required: Mem[0x05]=A5, Mem[0x04] and Mem[0x06] unchanged, `rdata` unchanged.
- Unaligned wrap: word write 32'hCAFEF00D at 0xFE. Required: Mem[FE]=CA, Mem[FF]=FE, Mem[00]=F0, Mem[01]=0D; a word read at 0xFE returns 32'hCAFEF00D.
- Assert `reset` during XFER cycle 2 of a word write of 32'hAABBCCDD at 0x40 (Mem preloaded with 00). Required: next cycle is IDLE with `busy`, `done` and `rdata` all 0, and Mem[0x40..0x43]=AA BB 00 00.
- Toggle `datamem_en`, `addr` and `wdata` during an active word read. Required: the result equals the originally latched access and no second access starts until IDLE.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the MEM-stage data-memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic SIZE_BYTE = 1'b1;
  localparam logic SIZE_WORD = 1'b0;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface data_mem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              datamem_en;
  logic              rw;
  logic              size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              busy;
  logic              done;

  modport master (
    output datamem_en, rw, size, addr, wdata,
    input  rdata, busy, done
  );

  modport slave (
    input  datamem_en, rw, size, addr, wdata,
    output rdata, busy, done
  );
endinterface

// File: rtl/data_mem_responder_ram.sv
// Single-port byte-wide storage: synchronous write, asynchronous read.
// Not cleared by reset; the bench preloads Mem hierarchically.
module data_ram_byte #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] Mem [0:DEPTH-1];

  // Byte write on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) Mem[addr] <= wdata;
  end

  assign rdata = Mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Byte-serial data-memory responder: one array byte per XFER cycle,
// big-endian word image {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for datamem_en; request fields latched on accept
// XFER    | one byte per cycle at (A+k) mod DEPTH; leave after last byte
// DONE    | one-cycle done pulse, rdata already valid; back to IDLE
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a_q;
  logic              rw_q;
  logic              sz_q;
  logic [31:0]       wd_q;
  logic [1:0]        k_q;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rdata_q;

  logic              last_byte;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;

  assign last_byte = (sz_q == SIZE_BYTE) || (k_q == 2'd3);
  assign ram_addr  = a_q + ADDR_W'(k_q);
  assign ram_we    = (state_q == ST_XFER) && (rw_q == RW_WRITE);

  data_ram_byte #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Store byte select (MSB first for words) and load lane merge.
  always_comb begin
    ram_wdata = wd_q[7:0];
    asm_d     = asm_q;
    if (sz_q == SIZE_BYTE) begin
      asm_d = {24'h0, ram_rdata};
    end else begin
      case (k_q)
        2'd0: begin ram_wdata = wd_q[31:24]; asm_d[31:24] = ram_rdata; end
        2'd1: begin ram_wdata = wd_q[23:16]; asm_d[23:16] = ram_rdata; end
        2'd2: begin ram_wdata = wd_q[15:8];  asm_d[15:8]  = ram_rdata; end
        default: begin ram_wdata = wd_q[7:0]; asm_d[7:0]  = ram_rdata; end
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.datamem_en) state_d = ST_XFER;
      ST_XFER: if (last_byte)      state_d = ST_DONE;
      ST_DONE:                     state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Request latch, byte counter, load assembly and result register.
  // rdata is loaded from the merged value on the last XFER edge so it is
  // already valid during the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      rw_q    <= RW_READ;
      sz_q    <= SIZE_WORD;
      wd_q    <= '0;
      k_q     <= 2'd0;
      asm_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.datamem_en) begin
            a_q  <= bus.addr;
            rw_q <= bus.rw;
            sz_q <= bus.size;
            wd_q <= bus.wdata;
            k_q  <= 2'd0;
          end
        end
        ST_XFER: begin
          if (rw_q == RW_READ) begin
            asm_q <= asm_d;
            if (last_byte) rdata_q <= asm_d;
          end
          if (!last_byte) k_q <= k_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes the expected
// rdata and completion cycle; a monitor pops on every done pulse.
module tb_data_mem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  data_mem_responder_if #(.ADDR_W(8)) bus ();

  data_mem_responder #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done at cycle %0d with nothing pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.rdata !== e.rdata || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s: rdata %h at cycle %0d, expected %h at cycle %0d",
                   e.name, bus.rdata, cyc, e.rdata, e.cyc);
        end
      end
    end
  end

  task automatic push_exp(input string nm, input logic [31:0] rd, input int lat);
    exp_t e;
    e.rdata = rd;
    e.cyc   = cyc + lat;
    e.name  = nm;
    sb.push_back(e);
  endtask

  task automatic drive(input logic r, input logic s, input logic [7:0] a, input logic [31:0] wd);
    bus.datamem_en = 1'b1;
    bus.rw         = r;
    bus.size       = s;
    bus.addr       = a;
    bus.wdata      = wd;
  endtask

  // Called at a negedge in an IDLE cycle; returns at a negedge in the IDLE gap.
  task automatic access(input string nm, input logic r, input logic s,
                        input logic [7:0] a, input logic [31:0] wd, input logic [31:0] exp);
    push_exp(nm, exp, (s == 1'b1) ? 2 : 5);
    drive(r, s, a, wd);
    @(negedge clk);
    bus.datamem_en = 1'b0;
    for (int t = 0; t < 10 && bus.done !== 1'b1; t++) @(negedge clk);
    if (bus.done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: done not seen", nm);
    end
    @(negedge clk);
  endtask

  task automatic chk_mem(input string nm, input logic [7:0] a, input logic [7:0] exp);
    chk(nm, {24'h0, dut.ram.Mem[a]}, {24'h0, exp});
  endtask

  initial begin
    bus.datamem_en = 1'b0;
    bus.rw         = 1'b1;
    bus.size       = 1'b0;
    bus.addr       = 8'h00;
    bus.wdata      = 32'h0;

    repeat (2) @(negedge clk);
    chk("reset_busy",  {31'h0, bus.busy}, 32'h0);
    chk("reset_done",  {31'h0, bus.done}, 32'h0);
    chk("reset_rdata", bus.rdata, 32'h0);

    for (int i = 0; i < 256; i++) dut.ram.Mem[i] <= 8'h00;
    dut.ram.Mem[8'h10] <= 8'hDE;
    dut.ram.Mem[8'h11] <= 8'hAD;
    dut.ram.Mem[8'h12] <= 8'hBE;
    dut.ram.Mem[8'h13] <= 8'hEF;
    dut.ram.Mem[8'h04] <= 8'h44;
    dut.ram.Mem[8'h06] <= 8'h66;
    reset = 1'b0;
    @(negedge clk);

    // Word read with busy profile over cycles 1..6.
    push_exp("t1_word_read", 32'hDEADBEEF, 5);
    drive(1'b1, 1'b0, 8'h10, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) bus.datamem_en = 1'b0;
      chk($sformatf("t1_busy_c%0d", i), {31'h0, bus.busy}, (i <= 5) ? 32'h1 : 32'h0);
    end
    chk("t1_rdata_held", bus.rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Word write then byte read from its middle.
    access("t2_word_write", 1'b0, 1'b0, 8'h20, 32'h11223344, 32'hDEADBEEF);
    access("t2_byte_read",  1'b1, 1'b1, 8'h22, 32'h0,        32'h00000033);
    chk_mem("t2_mem20", 8'h20, 8'h11);
    chk_mem("t2_mem21", 8'h21, 8'h22);
    chk_mem("t2_mem22", 8'h22, 8'h33);
    chk_mem("t2_mem23", 8'h23, 8'h44);

    // Byte write touches only one byte and leaves rdata alone.
    access("t3_byte_write", 1'b0, 1'b1, 8'h05, 32'hFFFFFFA5, 32'h00000033);
    chk_mem("t3_mem05", 8'h05, 8'hA5);
    chk_mem("t3_mem04", 8'h04, 8'h44);
    chk_mem("t3_mem06", 8'h06, 8'h66);

    // Unaligned word across the top of the array.
    access("t4_wrap_write", 1'b0, 1'b0, 8'hFE, 32'hCAFEF00D, 32'h00000033);
    chk_mem("t4_memFE", 8'hFE, 8'hCA);
    chk_mem("t4_memFF", 8'hFF, 8'hFE);
    chk_mem("t4_mem00", 8'h00, 8'hF0);
    chk_mem("t4_mem01", 8'h01, 8'h0D);
    access("t4_wrap_read", 1'b1, 1'b0, 8'hFE, 32'h0, 32'hCAFEF00D);

    // Reset during XFER cycle 2 of a word write.
    drive(1'b0, 1'b0, 8'h40, 32'hAABBCCDD);
    @(negedge clk);
    bus.datamem_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_busy",  {31'h0, bus.busy}, 32'h0);
    chk("t5_done",  {31'h0, bus.done}, 32'h0);
    chk("t5_rdata", bus.rdata, 32'h0);
    chk_mem("t5_mem40", 8'h40, 8'hAA);
    chk_mem("t5_mem41", 8'h41, 8'hBB);
    chk_mem("t5_mem42", 8'h42, 8'h00);
    chk_mem("t5_mem43", 8'h43, 8'h00);
    drive(1'b1, 1'b1, 8'h10, 32'h0);
    @(negedge clk);
    chk("t5_reset_wins", {31'h0, bus.busy}, 32'h0);
    bus.datamem_en = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Inputs toggled throughout an active word read.
    push_exp("t6_toggle_read", 32'h11223344, 5);
    drive(1'b1, 1'b0, 8'h20, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("t6_busy_c%0d", i), {31'h0, bus.busy}, 32'h1);
      bus.datamem_en = i[0];
      bus.rw         = 1'b0;
      bus.size       = 1'b1;
      bus.addr       = 8'h10 + 8'(i);
      bus.wdata      = $urandom;
    end
    @(negedge clk);
    bus.datamem_en = 1'b0;
    chk("t6_idle_gap", {31'h0, bus.busy}, 32'h0);
    @(negedge clk);
    chk("t6_no_restart", {31'h0, bus.busy}, 32'h0);
    chk_mem("t6_mem11", 8'h11, 8'hAD);
    chk_mem("t6_mem13", 8'h13, 8'hEF);
    chk_mem("t6_mem14", 8'h14, 8'h00);
    chk_mem("t6_mem15", 8'h15, 8'h00);
    chk_mem("t6_mem20", 8'h20, 8'h11);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
